// File: rtl/cv_weights_fetcher.sv
// cv_weights_fetcher: walks a window of the weights buffer one row per
// granted feature-map strobe. The walk covers base address, rows per tile,
// repeats of the same group and several output-channel groups. Row data,
// valid and last-row tags are aligned to the BRAM read latency.
// Optional build macro WEIGHTS_PERF_CNT_EN adds read/stall counters.
module cv_weights_fetcher #(
    parameter int WEIGHTS_IN_ROW = 64,
    parameter int WEIGHT_BITS    = 8,
    parameter int ADDR_W         = 11,
    parameter int RD_LATENCY     = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_start,
    input  logic [ADDR_W-1:0]                    i_cfg_base_addr,
    input  logic [ADDR_W-1:0]                    i_cfg_rows,
    input  logic [7:0]                           i_cfg_repeat,
    input  logic [7:0]                           i_cfg_groups,
    input  logic                                 i_re_fm_en,
    output logic                                 o_mem_en,
    output logic [ADDR_W-1:0]                    o_mem_addr,
    input  logic [WEIGHTS_IN_ROW*WEIGHT_BITS-1:0] i_mem_dout,
    output logic [WEIGHTS_IN_ROW*WEIGHT_BITS-1:0] o_weights_vector,
    output logic                                 o_weights_valid,
    output logic                                 o_row_last,
    output logic                                 o_busy,
    output logic                                 o_done
`ifdef WEIGHTS_PERF_CNT_EN
    ,
    output logic [31:0]                          o_rd_count,
    output logic [31:0]                          o_stall_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ADDR_W-1:0]     r_grpBase;
    logic [ADDR_W-1:0]     r_rows;
    logic [7:0]            r_repeat;
    logic [7:0]            r_groups;
    logic [ADDR_W-1:0]     r_row;
    logic [7:0]            r_rep;
    logic [7:0]            r_grp;
    logic [RD_LATENCY-1:0] r_validPipe;
    logic [RD_LATENCY-1:0] r_lastPipe;

    logic w_accept;
    logic w_emptyJob;
    logic w_issue;
    logic w_lastRow;
    logic w_lastRep;
    logic w_lastGrp;
    logic w_finalIssue;
    logic w_inFlight;

    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_emptyJob   = (i_cfg_rows == '0) || (i_cfg_repeat == 8'd0) || (i_cfg_groups == 8'd0);
    assign w_lastRow    = (r_row == r_rows - ADDR_W'(1));
    assign w_lastRep    = (r_rep == r_repeat - 8'd1);
    assign w_lastGrp    = (r_grp == r_groups - 8'd1);
    assign w_finalIssue = w_lastRow && w_lastRep && w_lastGrp;

    assign o_mem_en         = w_issue;
    assign o_mem_addr       = r_grpBase + r_row;
    assign o_weights_valid  = r_validPipe[RD_LATENCY-1];
    assign o_row_last       = r_lastPipe[RD_LATENCY-1];
    assign o_weights_vector = o_weights_valid ? i_mem_dout : '0;
    assign o_busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done           = (r_state == S_DONE);

    // State register; reset abandons any job without a done pulse
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    // Next-state and read issue; DRAIN leaves once only the tail stage can still hold a row
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_nextState = w_emptyJob ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_issue = i_re_fm_en;
                if (i_re_fm_en && w_finalIssue) w_nextState = S_DRAIN;
            end
            S_DRAIN: begin
                if (!w_inFlight) w_nextState = S_DONE;
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Rows still in flight ahead of the output stage
    always_comb begin
        w_inFlight = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) w_inFlight = w_inFlight | r_validPipe[i];
    end

    // Config capture on accepted start, then row/repeat/group walk per issued read
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grpBase <= '0;
            r_rows    <= '0;
            r_repeat  <= '0;
            r_groups  <= '0;
            r_row     <= '0;
            r_rep     <= '0;
            r_grp     <= '0;
        end else if (w_accept) begin
            r_grpBase <= i_cfg_base_addr;
            r_rows    <= i_cfg_rows;
            r_repeat  <= i_cfg_repeat;
            r_groups  <= i_cfg_groups;
            r_row     <= '0;
            r_rep     <= '0;
            r_grp     <= '0;
        end else if (w_issue) begin
            if (w_lastRow) begin
                r_row <= '0;
                if (w_lastRep) begin
                    r_rep     <= '0;
                    r_grp     <= r_grp + 8'd1;
                    r_grpBase <= r_grpBase + r_rows;
                end else begin
                    r_rep <= r_rep + 8'd1;
                end
            end else begin
                r_row <= r_row + ADDR_W'(1);
            end
        end
    end

    // Valid/last tags travel alongside the BRAM latency, advancing every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_validPipe <= '0;
            r_lastPipe  <= '0;
        end else begin
            r_validPipe[0] <= w_issue;
            r_lastPipe[0]  <= w_issue && w_lastRow;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_validPipe[i] <= r_validPipe[i-1];
                r_lastPipe[i]  <= r_lastPipe[i-1];
            end
        end
    end

`ifdef WEIGHTS_PERF_CNT_EN
    logic [31:0] r_rdCount;
    logic [31:0] r_stallCount;

    assign o_rd_count    = r_rdCount;
    assign o_stall_count = r_stallCount;

    // Saturating counts of issued reads and stalled RUN cycles, held after done
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_rdCount    <= '0;
            r_stallCount <= '0;
        end else if (r_state == S_RUN) begin
            if (i_re_fm_en) begin
                if (r_rdCount != 32'hFFFF_FFFF) r_rdCount <= r_rdCount + 32'd1;
            end else begin
                if (r_stallCount != 32'hFFFF_FFFF) r_stallCount <= r_stallCount + 32'd1;
            end
        end
    end
`else
    // Counters are not built; the fetch path is unchanged.
`endif

endmodule

// File: tb/tb_cv_weights_fetcher.sv
// tb_cv_weights_fetcher: drives two fetchers (read latency 1 and 3) with the
// same stimulus and compares them against a job-level reference model that
// expands each accepted job into its full ordered list of row addresses.
// Define WEIGHTS_PERF_CNT_EN to also compare the read/stall counters.
module tb_cv_weights_fetcher;

    localparam int AW = 11;
    localparam int W  = 512;

    typedef struct {
        logic [AW-1:0] addr;
        logic          last;
        int            due;
    } row_t;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic reFmEn;
    logic [AW-1:0] cfgBase;
    logic [AW-1:0] cfgRows;
    logic [7:0]    cfgRep;
    logic [7:0]    cfgGrp;

    logic          memEn   [2];
    logic [AW-1:0] memAddr [2];
    logic [W-1:0]  memDout [2];
    logic [W-1:0]  wVec    [2];
    logic          wValid  [2];
    logic          rowLast [2];
    logic          busy    [2];
    logic          done    [2];
`ifdef WEIGHTS_PERF_CNT_EN
    logic [31:0]   rdCnt    [2];
    logic [31:0]   stallCnt [2];
`endif

    row_t issueQ [2][$];
    row_t validQ [2][$];
    bit   issuing [2];
    int   doneDue [2];
    int   rdM     [2];
    int   stallM  [2];
    int   cyc;
    bit   checkEn;
    int   compared;
    int   mismatched;

    // Free-running clock
    always #5 clk = ~clk;

    cv_weights_fetcher #(.RD_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .i_start(start),
        .i_cfg_base_addr(cfgBase), .i_cfg_rows(cfgRows),
        .i_cfg_repeat(cfgRep), .i_cfg_groups(cfgGrp),
        .i_re_fm_en(reFmEn), .o_mem_en(memEn[0]), .o_mem_addr(memAddr[0]),
        .i_mem_dout(memDout[0]), .o_weights_vector(wVec[0]),
        .o_weights_valid(wValid[0]), .o_row_last(rowLast[0]),
        .o_busy(busy[0]), .o_done(done[0])
`ifdef WEIGHTS_PERF_CNT_EN
        , .o_rd_count(rdCnt[0]), .o_stall_count(stallCnt[0])
`endif
    );

    cv_weights_fetcher #(.RD_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .i_start(start),
        .i_cfg_base_addr(cfgBase), .i_cfg_rows(cfgRows),
        .i_cfg_repeat(cfgRep), .i_cfg_groups(cfgGrp),
        .i_re_fm_en(reFmEn), .o_mem_en(memEn[1]), .o_mem_addr(memAddr[1]),
        .i_mem_dout(memDout[1]), .o_weights_vector(wVec[1]),
        .o_weights_valid(wValid[1]), .o_row_last(rowLast[1]),
        .o_busy(busy[1]), .o_done(done[1])
`ifdef WEIGHTS_PERF_CNT_EN
        , .o_rd_count(rdCnt[1]), .o_stall_count(stallCnt[1])
`endif
    );

    // Row contents derived from the address so every row is distinguishable
    function automatic logic [W-1:0] dataOf(input logic [AW-1:0] a);
        logic [W-1:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = {a, 5'(i), 16'(a * 16'hA5C3 + i)};
        return v;
    endfunction

    function automatic int latOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // BRAM models with read latency 1 and 3
    logic [W-1:0] d0;
    logic [W-1:0] d1 [3];
    always @(posedge clk) begin
        d0    <= dataOf(memAddr[0]);
        d1[0] <= dataOf(memAddr[1]);
        d1[1] <= d1[0];
        d1[2] <= d1[1];
    end
    assign memDout[0] = d0;
    assign memDout[1] = d1[2];

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, then advance the model across the edge
    task automatic applyStimulus(input logic st, input logic re, input logic rs);
        bit   en  [2];
        bit   vld [2];
        bit   busyNow;
        row_t v;
        int   a;
        start  = st;
        reFmEn = re;
        reset  = rs;
        #1;
        for (int k = 0; k < 2; k++) begin
            en[k]  = issuing[k] && re;
            vld[k] = (validQ[k].size() > 0) && (validQ[k][0].due == cyc);
            if (checkEn) begin
                checkOutput($sformatf("memEn%0d", k), W'(memEn[k]), W'(en[k]));
                if (en[k]) checkOutput($sformatf("memAddr%0d", k), W'(memAddr[k]), W'(issueQ[k][0].addr));
                checkOutput($sformatf("valid%0d", k), W'(wValid[k]), W'(vld[k]));
                checkOutput($sformatf("rowLast%0d", k), W'(rowLast[k]), W'(vld[k] && validQ[k][0].last));
                checkOutput($sformatf("vector%0d", k), wVec[k], vld[k] ? dataOf(validQ[k][0].addr) : '0);
                checkOutput($sformatf("busy%0d", k), W'(busy[k]), W'(issuing[k] || validQ[k].size() > 0));
                checkOutput($sformatf("done%0d", k), W'(done[k]), W'(cyc == doneDue[k]));
`ifdef WEIGHTS_PERF_CNT_EN
                checkOutput($sformatf("rdCount%0d", k), W'(rdCnt[k]), W'(rdM[k]));
                checkOutput($sformatf("stallCount%0d", k), W'(stallCnt[k]), W'(stallM[k]));
`endif
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                issueQ[k].delete();
                validQ[k].delete();
                issuing[k] = 0;
                doneDue[k] = -1;
                rdM[k]     = 0;
                stallM[k]  = 0;
            end else begin
                busyNow = issuing[k] || (validQ[k].size() > 0);
                if (vld[k]) void'(validQ[k].pop_front());
                if (issuing[k]) begin
                    if (re) rdM[k]++;
                    else    stallM[k]++;
                end
                if (en[k]) begin
                    v     = issueQ[k].pop_front();
                    v.due = cyc + latOf(k);
                    validQ[k].push_back(v);
                    if (issueQ[k].size() == 0) begin
                        issuing[k] = 0;
                        doneDue[k] = cyc + latOf(k) + 1;
                    end
                end
                if (st && !busyNow && (cyc != doneDue[k])) begin
                    rdM[k]    = 0;
                    stallM[k] = 0;
                    for (int g = 0; g < int'(cfgGrp); g++)
                        for (int r = 0; r < int'(cfgRep); r++)
                            for (int row = 0; row < int'(cfgRows); row++) begin
                                a      = int'(cfgBase) + g * int'(cfgRows) + row;
                                v.addr = a[AW-1:0];
                                v.last = (row == int'(cfgRows) - 1);
                                v.due  = 0;
                                issueQ[k].push_back(v);
                            end
                    if (issueQ[k].size() == 0) doneDue[k] = cyc + 1;
                    else                        issuing[k] = 1;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit allIdle();
        bit idle = 1;
        for (int k = 0; k < 2; k++)
            if (issuing[k] || validQ[k].size() > 0 || doneDue[k] >= cyc) idle = 0;
        return idle;
    endfunction

    // Run one job to completion; reMode 0 = always on, 1 = fixed stall pattern, 2 = random
    task automatic runJob(input int base, input int rows, input int rep, input int grp,
                          input int reMode, input bit noise);
        bit pattern [7] = '{1, 0, 0, 1, 1, 0, 1};
        bit re;
        bit st;
        bit finished = 0;
        cfgBase = AW'(base);
        cfgRows = AW'(rows);
        cfgRep  = 8'(rep);
        cfgGrp  = 8'(grp);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 2000; n++) begin
            if (allIdle()) begin
                finished = 1;
                break;
            end
            case (reMode)
                0:       re = 1;
                1:       re = pattern[n % 7];
                default: re = ($urandom_range(0, 9) < 7);
            endcase
            st = noise && issuing[0] && issuing[1] && ($urandom_range(0, 7) == 0);
            if (noise) begin
                cfgBase = AW'($urandom);
                cfgRows = AW'($urandom_range(0, 9));
                cfgRep  = 8'($urandom_range(0, 4));
                cfgGrp  = 8'($urandom_range(0, 4));
            end
            applyStimulus(st, re, 1'b0);
        end
        checkOutput("jobFinished", W'(finished), W'(1));
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        checkEn    = 0;
        for (int k = 0; k < 2; k++) begin
            issuing[k] = 0;
            doneDue[k] = -1;
            rdM[k]     = 0;
            stallM[k]  = 0;
        end
        start   = 0;
        reFmEn  = 0;
        reset   = 1;
        cfgBase = '0;
        cfgRows = '0;
        cfgRep  = '0;
        cfgGrp  = '0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkEn = 1;
        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] single tile, strobe held high");
        runJob(12'h010, 4, 1, 1, 0, 0);

        $display("[TB] repeats and groups");
        runJob(12'h100, 3, 2, 2, 0, 0);

        $display("[TB] stalled strobe pattern");
        runJob(12'h020, 4, 1, 1, 1, 0);

        $display("[TB] empty jobs");
        runJob(12'h040, 4, 1, 0, 0, 0);
        runJob(12'h040, 0, 2, 2, 0, 0);
        runJob(12'h040, 3, 0, 1, 0, 0);

        $display("[TB] address wrap");
        runJob(12'h7FE, 4, 1, 1, 0, 0);
        runJob(12'h7FD, 2, 2, 3, 2, 0);

        $display("[TB] reset in the middle of a job");
        cfgBase = 11'h200;
        cfgRows = 11'd8;
        cfgRep  = 8'd1;
        cfgGrp  = 8'd1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        runJob(12'h200, 8, 1, 1, 0, 0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 30; j++) begin
            int rows = $urandom_range(1, 6);
            int rep  = $urandom_range(1, 3);
            int grp  = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) grp = 0;
            runJob(int'($urandom_range(0, 2047)), rows, rep, grp, 2, 1);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++)
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
